// File: rtl/seg_display_mux_if.sv
// ---------------------------------------------------------------------------
// seg_display_mux_if
//   Bundle of the display-multiplexer data/control signals.
//
//   value       4*NUM_DIGITS  hex value, nibble i -> digit i (digit 0 rightmost)
//   load        1             single-cycle strobe capturing value
//   digit_mask  NUM_DIGITS    bit i = 1 enables digit i
//   lz_blank    1             1 enables leading-zero blanking
//   out7        7             active-low segments {g,f,e,d,c,b,a}
//   en_out      NUM_DIGITS    active-low digit enables
//   frame_done  1             one-cycle pulse at each scan-frame boundary
//
//   master: the client that supplies the value and observes the display pins.
//   slave : the multiplexer itself.
// ---------------------------------------------------------------------------
interface seg_display_mux_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] value;
    logic                    load;
    logic [NUM_DIGITS-1:0]   digit_mask;
    logic                    lz_blank;
    logic [6:0]              out7;
    logic [NUM_DIGITS-1:0]   en_out;
    logic                    frame_done;

    modport master (
        output value, load, digit_mask, lz_blank,
        input  out7, en_out, frame_done
    );

    modport slave (
        input  value, load, digit_mask, lz_blank,
        output out7, en_out, frame_done
    );
endinterface

// File: rtl/seg_display_mux.sv
// ---------------------------------------------------------------------------
// seg_display_mux
//   Time-multiplexed driver for a common-anode style hex display.
//   A prescaler lights each digit for REFRESH_DIV cycles; the digit index
//   walks 0..NUM_DIGITS-1. The displayed value is double-buffered: a load
//   goes into a pending register and is only promoted to the active register
//   at the end of a scan frame, so a frame never shows a mix of two values.
//
//   Parameters
//     NUM_DIGITS   number of digits, 1..16
//     REFRESH_DIV  clk cycles per digit, >= 1
//
//   Ports
//     clk    single clock, rising edge
//     rst    asynchronous, active-low reset (0 = reset)
//     disp   seg_display_mux_if.slave: value/load/digit_mask/lz_blank in,
//            out7/en_out/frame_done out (all outputs registered)
// ---------------------------------------------------------------------------
module seg_display_mux #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    seg_display_mux_if.slave  disp
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = 4 * NUM_DIGITS;

    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [PW-1:0]         presc_reg,   presc_next;
    logic [IW-1:0]         index_reg,   index_next;
    logic [VW-1:0]         pending_reg, pending_next;
    logic [VW-1:0]         active_reg,  active_next;
    logic [6:0]            seg_reg,     seg_next;
    logic [NUM_DIGITS-1:0] en_reg,      en_next;
    logic                  frame_done_reg, frame_done_next;

    logic tick;
    logic frame_end;

    // Per-digit views of the active register.
    logic [3:0]            nibble [NUM_DIGITS];
    // nonzero_from[i] = 1 when any nibble i..NUM_DIGITS-1 is non-zero; a
    // digit is a leading zero exactly when this is 0.
    logic [NUM_DIGITS-1:0] nonzero_from;

    logic [3:0] cur_nibble;
    logic       blanked;
    logic       shown;

    // -----------------------------------------------------------------------
    // Hex to active-low 7-segment code, {g,f,e,d,c,b,a}
    // -----------------------------------------------------------------------
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nibble[gi]       = active_reg[4*gi +: 4];
            assign nonzero_from[gi] = |active_reg[VW-1:4*gi];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Scan timing and double buffer
    // -----------------------------------------------------------------------
    always_comb begin
        tick      = (presc_reg == PRESC_MAX);
        frame_end = tick && (index_reg == IDX_MAX);

        presc_next = tick ? '0 : presc_reg + PW'(1);

        index_next = index_reg;
        if (tick) begin
            index_next = (index_reg == IDX_MAX) ? '0 : index_reg + IW'(1);
        end

        // A load coinciding with the frame boundary goes straight to the
        // active register so it is not delayed by a whole frame.
        pending_next = disp.load ? disp.value : pending_reg;
        active_next  = active_reg;
        if (frame_end) begin
            active_next = disp.load ? disp.value : pending_reg;
        end

        frame_done_next = frame_end;
    end

    // -----------------------------------------------------------------------
    // Digit decode for the current index (registered below, so outputs lag
    // the index by one cycle and no input reaches an output combinationally)
    // -----------------------------------------------------------------------
    always_comb begin
        cur_nibble = nibble[index_reg];
        blanked    = disp.lz_blank && (index_reg != '0) && !nonzero_from[index_reg];
        shown      = disp.digit_mask[index_reg] && !blanked;

        seg_next = 7'h7F;
        en_next  = '1;
        if (shown) begin
            seg_next           = hex_to_seg(cur_nibble);
            en_next[index_reg] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_reg      <= '0;
            index_reg      <= '0;
            pending_reg    <= '0;
            active_reg     <= '0;
            seg_reg        <= 7'h7F;
            en_reg         <= '1;
            frame_done_reg <= 1'b0;
        end else begin
            presc_reg      <= presc_next;
            index_reg      <= index_next;
            pending_reg    <= pending_next;
            active_reg     <= active_next;
            seg_reg        <= seg_next;
            en_reg         <= en_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign disp.out7       = seg_reg;
    assign disp.en_out     = en_reg;
    assign disp.frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_display_mux.sv
module tb_seg_display_mux;

    localparam int N = 8;
    localparam int R = 4;
    localparam int FRAME = N * R;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seg_display_mux_if #(.NUM_DIGITS(N)) bus ();
    seg_display_mux_if #(.NUM_DIGITS(1)) bus1 ();

    seg_display_mux #(.NUM_DIGITS(N), .REFRESH_DIV(R)) dut (
        .clk  (clk),
        .rst  (rst),
        .disp (bus)
    );

    seg_display_mux #(.NUM_DIGITS(1), .REFRESH_DIV(1)) dut1 (
        .clk  (clk),
        .rst  (rst),
        .disp (bus1)
    );

    // Segment codes straight from the decode table, indexed by nibble.
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int checks   = 0;
    int failures = 0;

    // Reference model: the scan position is derived purely from the number
    // of clock edges since reset release.
    int          cyc;
    logic [31:0] m_active;
    logic [31:0] m_pending;
    logic [7:0]  exp_en;
    logic [6:0]  exp_seg;
    logic        exp_fd;
    int          seen_00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic ld, input logic [31:0] v,
                              input logic [7:0] m, input logic lz);
        int   idx;
        bit   bnd;
        bit   shown;
        logic [3:0] nib;
        idx   = (cyc / R) % N;
        bnd   = ((cyc + 1) % FRAME) == 0;
        nib   = m_active[idx*4 +: 4];
        shown = m[idx] && !(lz && idx > 0 && (m_active >> (4 * idx)) == 32'd0);
        exp_en  = 8'hFF;
        exp_seg = 7'h7F;
        if (shown) begin
            exp_en[idx] = 1'b0;
            exp_seg     = seg_tab[nib];
        end
        exp_fd = bnd;
        if (bnd) m_active = ld ? v : m_pending;
        if (ld)  m_pending = v;
        cyc++;
    endtask

    // One clock: drive at negedge, model at posedge, check at next negedge.
    task automatic step(input logic ld, input logic [31:0] v,
                        input logic [7:0] m, input logic lz);
        bus.load       = ld;
        bus.value      = v;
        bus.digit_mask = m;
        bus.lz_blank   = lz;
        bus1.load       = 1'($urandom_range(0, 1));
        bus1.value      = 4'($urandom);
        bus1.lz_blank   = 1'($urandom_range(0, 1));
        bus1.digit_mask = 1'b0;
        if (ld) $display("load value=%h mask=%h lz=%0d cyc=%0d", v, m, lz, cyc);
        @(posedge clk);
        model_edge(ld, v, m, lz);
        @(negedge clk);
        check("en_out", {24'd0, bus.en_out}, {24'd0, exp_en});
        check("out7", {25'd0, bus.out7}, {25'd0, exp_seg});
        check("frame_done", {31'd0, bus.frame_done}, {31'd0, exp_fd});
        check("n1_en_out", {31'd0, bus1.en_out}, 32'd1);
        check("n1_out7", {25'd0, bus1.out7}, 32'h7F);
        check("n1_frame_done", {31'd0, bus1.frame_done}, 32'd1);
        if (bus.out7 == 7'h00 && bus.en_out != 8'hFF) seen_00++;
    endtask

    task automatic idle(input int n, input logic [7:0] m, input logic lz);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, m, lz);
    endtask

    // Step until the edge just taken was a frame boundary (bounded).
    task automatic run_to_boundary(input logic [7:0] m, input logic lz);
        int k;
        k = 0;
        while (!exp_fd && k < 4 * FRAME) begin
            step(1'b0, 32'd0, m, lz);
            k++;
        end
        check("boundary_reached", {31'd0, exp_fd}, 32'd1);
    endtask

    // Asynchronous reset asserted between edges; called at a negedge.
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        $display("reset asserted t=%0t", $time);
        check("rst_en_out", {24'd0, bus.en_out}, 32'hFF);
        check("rst_out7", {25'd0, bus.out7}, 32'h7F);
        check("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
        check("rst_n1_frame_done", {31'd0, bus1.frame_done}, 32'd0);
        m_active  = 32'd0;
        m_pending = 32'd0;
        cyc       = 0;
        exp_fd    = 1'b0;
        @(negedge clk);
        check("rst_hold_en_out", {24'd0, bus.en_out}, 32'hFF);
        check("rst_hold_out7", {25'd0, bus.out7}, 32'h7F);
        rst = 1'b1;
    endtask

    initial begin
        bus.load = 1'b0; bus.value = '0; bus.digit_mask = '1; bus.lz_blank = 1'b0;
        bus1.load = 1'b0; bus1.value = '0; bus1.digit_mask = '0; bus1.lz_blank = 1'b0;
        cyc = 0; m_active = 0; m_pending = 0; exp_fd = 0; seen_00 = 0;

        @(negedge clk);
        check("init_en_out", {24'd0, bus.en_out}, 32'hFF);
        check("init_out7", {25'd0, bus.out7}, 32'h7F);
        check("init_frame_done", {31'd0, bus.frame_done}, 32'd0);
        rst = 1'b1;

        // Reset contents (zero) on all digits, then a mid-scan async reset.
        idle(13, 8'hFF, 1'b0);
        do_reset();

        // Value 0123_4567, no blanking.
        step(1'b1, 32'h0123_4567, 8'hFF, 1'b0);
        run_to_boundary(8'hFF, 1'b0);
        step(1'b0, 32'd0, 8'hFF, 1'b0);
        check("d0_en", {24'd0, bus.en_out}, 32'hFE);
        check("d0_seg", {25'd0, bus.out7}, 32'h78);
        idle(28, 8'hFF, 1'b0);
        check("d7_en", {24'd0, bus.en_out}, 32'h7F);
        check("d7_seg", {25'd0, bus.out7}, 32'h40);
        idle(3, 8'hFF, 1'b0);
        check("frame_period", {31'd0, bus.frame_done}, 32'd1);

        // Leading-zero blanking of 0000_00A0.
        step(1'b1, 32'h0000_00A0, 8'hFF, 1'b1);
        run_to_boundary(8'hFF, 1'b1);
        step(1'b0, 32'd0, 8'hFF, 1'b1);
        check("lz_d0_seg", {25'd0, bus.out7}, 32'h40);
        idle(4, 8'hFF, 1'b1);
        check("lz_d1_en", {24'd0, bus.en_out}, 32'hFD);
        check("lz_d1_seg", {25'd0, bus.out7}, 32'h08);
        idle(4, 8'hFF, 1'b1);
        check("lz_d2_en", {24'd0, bus.en_out}, 32'hFF);
        check("lz_d2_seg", {25'd0, bus.out7}, 32'h7F);

        // All zero with blanking: only digit 0 lights.
        step(1'b1, 32'h0, 8'hFF, 1'b1);
        run_to_boundary(8'hFF, 1'b1);
        idle(FRAME, 8'hFF, 1'b1);

        // X loaded mid-frame, Y loaded in the boundary cycle: X never shown.
        seen_00 = 0;
        idle(5, 8'hFF, 1'b0);
        step(1'b1, 32'h8888_8888, 8'hFF, 1'b0);
        for (int k = 0; k < FRAME && ((cyc + 1) % FRAME) != 0; k++) step(1'b0, 32'd0, 8'hFF, 1'b0);
        step(1'b1, 32'h1111_1111, 8'hFF, 1'b0);
        check("y_boundary", {31'd0, bus.frame_done}, 32'd1);
        step(1'b0, 32'd0, 8'hFF, 1'b0);
        check("y_d0_seg", {25'd0, bus.out7}, 32'h79);
        idle(FRAME, 8'hFF, 1'b0);
        check("x_never_shown", seen_00, 32'd0);

        // Pending load discarded by a mid-frame reset.
        idle(3, 8'hFF, 1'b0);
        step(1'b1, 32'hFFFF_FFFF, 8'hFF, 1'b0);
        idle(2, 8'hFF, 1'b0);
        do_reset();
        run_to_boundary(8'hFF, 1'b0);
        step(1'b0, 32'd0, 8'hFF, 1'b0);
        check("rst_discard_seg", {25'd0, bus.out7}, 32'h40);

        // Randomized traffic.
        for (int i = 0; i < 700; i++) begin
            step(($urandom_range(0, 15) == 0), $urandom, 8'($urandom), 1'($urandom_range(0, 1)));
            if (i == 350) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seg_display_mux.md
SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8: number of multiplexed digits; legal range 1..16.
REQ-002 SHALL have parameter REFRESH_DIV, default 100000: clk cycles each digit is lit; legal value >=1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low (0 = reset).
REQ-005 SHALL have port value, input, 4*NUM_DIGITS bits: hex value to show; nibble i drives digit i, and digit 0 is the rightmost.
REQ-006 SHALL have port load, input, 1 bit: single-cycle strobe that captures value.
REQ-007 SHALL have port digit_mask, input, NUM_DIGITS bits: bit i = 1 enables digit i.
REQ-008 SHALL have port lz_blank, input, 1 bit: 1 enables leading-zero blanking.
REQ-009 SHALL have port out7, output, 7 bits: active-low segments {g,f,e,d,c,b,a}, with a = bit 0.
REQ-010 SHALL have port en_out, output, NUM_DIGITS bits: active-low digit enables.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse marking the end of a scan frame.

Function
REQ-012 SHALL implement a prescaler that counts 0..REFRESH_DIV-1 and wraps to 0.
- tick is asserted in the cycle where prescaler = REFRESH_DIV-1.
- REFRESH_DIV = 1 gives tick every cycle.
REQ-013 SHALL hold a digit index 0..NUM_DIGITS-1 that increments on tick and wraps from NUM_DIGITS-1 to 0.
REQ-014 SHALL double-buffer the displayed value.
- load=1 writes value into the pending register.
- The active register SHALL update only at a frame boundary: a tick with index = NUM_DIGITS-1.
REQ-015 At a frame boundary, the active register SHALL take value if load=1 in the same cycle; otherwise it SHALL take pending.
- If load=1 in that cycle, pending SHALL also take value.
REQ-016 SHALL assert frame_done for exactly one cycle at each frame boundary.
REQ-017 SHALL register out7 and en_out, each updated every clk from the current index and active register (1-cycle lag behind index).
REQ-018 en_out SHALL have exactly one bit low, bit[index], when digit[index] is shown.
- A digit is shown only if digit_mask[index]=1 and it is not blanked.
- Otherwise en_out SHALL be all ones and out7 SHALL be 7'h7F.
REQ-019 When lz_blank=1, digit i>0 SHALL be blanked when nibbles i..NUM_DIGITS-1 of the active register are all zero.
- Digit 0 SHALL never be blanked.
REQ-020 SHALL decode nibbles 0..F to out7 as follows:
- 40, 79, 24, 30, 19, 12, 02, 78 (nibbles 0..7)
- 00, 10, 08, 03, 46, 21, 06, 0E (nibbles 8..F)
- All codes are hex.
REQ-021 digit_mask and lz_blank SHALL take effect on the next clk with no buffering.
REQ-022 The implementation SHALL contain no combinational path from any input to any output.

Reset
REQ-023 While rst=0, the block SHALL asynchronously hold the following reset values:
- prescaler = 0, index = 0, pending = 0, active = 0;
- out7 = 7'h7F, en_out = all ones, frame_done = 0.
REQ-024 After rst rises, the first tick SHALL occur REFRESH_DIV cycles later.
REQ-025 A reset asserted mid-frame SHALL discard any pending load.
- Scanning SHALL restart at digit 0.

Verification (NUM_DIGITS=8, REFRESH_DIV=4 unless stated)
REQ-026 Drive rst=0 mid-scan, asynchronously, between edges -> out7=7F, en_out=FF, frame_done=0 immediately, with no clk edge needed.
REQ-027 Load 32'h0123_4567, mask=FF, lz_blank=0 -> after the next frame boundary, each digit is lit for 4 cycles in order 0..7.
- Digit 0: en_out=FE, out7=78 ("7").
- Digit 7: en_out=7F, out7=40 ("0").
- frame_done pulses every 32 cycles.
REQ-028 Load 32'h0000_00A0, lz_blank=1 -> digits 2..7 show en_out=FF, out7=7F.
- Digit 1 shows 08 ("A").
- Digit 0 shows 40 ("0").
REQ-029 Load 32'h0000_0000, lz_blank=1 -> only digit 0 lights, with out7=40.
REQ-030 Load X mid-frame, then Y with load=1 in the frame-boundary cycle -> X is never displayed and Y is displayed from the following frame.
REQ-031 Set REFRESH_DIV=1, NUM_DIGITS=1, mask=0 -> en_out stays 1, out7 stays 7F, and frame_done=1 every cycle.
